sysid_checker: RTL and testbench

- Avalon-MM read master that consumes the system-ID slave's readdata port at boot and on demand.
- Reads word 0 (system ID) and word 1 (build timestamp), compares each against an expected value, and publishes sticky pass/fail status plus the captured words.
- Sits directly downstream of the system-ID slave; feeds the boot/status logic and LEDs.

---
 rtl/sysid_checker.sv | 181 ++++++++++++++++++
 tb/tb_sysid_checker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that reads the system-ID slave
// (word 0 = system ID, word 1 = build timestamp), compares both words with
// their expected values and publishes sticky status plus the captured words.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   start               single-cycle check request (ignored unless idle)
//   avm_address         0 = ID word, 1 = timestamp word
//   avm_read            read strobe
//   avm_waitrequest     slave stall
//   avm_readdata        slave read data
//   busy                check in progress
//   done                one-cycle pulse when a check ends
//   pass                sticky: last check passed
//   id_ok, ts_ok        sticky: ID / timestamp matched
//   timeout             sticky: last check aborted on waitrequest
//   id_value, ts_value  captured ID / timestamp words
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1444096058,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAT_LAST   = 3'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic [15:0] stall_q, stall_d;
  logic [2:0]  lat_q, lat_d;

  logic        avm_address_d, avm_read_d, busy_d, done_d, pass_d;
  logic        id_ok_d, ts_ok_d, timeout_d;
  logic [31:0] id_value_d, ts_value_d;

  logic        in_ts, capture, id_match, ts_match;

  assign in_ts    = (state_q == RD_TS) || (state_q == LAT_TS);
  assign id_match = (avm_readdata == EXPECTED_ID);
  assign ts_match = (avm_readdata == EXPECTED_TIMESTAMP) || !CHECK_TIMESTAMP;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      auto_q      <= AUTO_START;
      stall_q     <= '0;
      lat_q       <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      auto_q      <= auto_d;
      stall_q     <= stall_d;
      lat_q       <= lat_d;
      avm_address <= avm_address_d;
      avm_read    <= avm_read_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      id_ok       <= id_ok_d;
      ts_ok       <= ts_ok_d;
      timeout     <= timeout_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
    end
  end

  // Every output is a register; this block computes their next values so the
  // bus strobes change only on clock edges (no avm_* input-to-output path).
  always_comb begin
    state_d       = state_q;
    auto_d        = auto_q;
    stall_d       = stall_q;
    lat_d         = lat_q;
    avm_address_d = avm_address;
    avm_read_d    = avm_read;
    busy_d        = busy;
    done_d        = 1'b0;
    pass_d        = pass;
    id_ok_d       = id_ok;
    ts_ok_d       = ts_ok;
    timeout_d     = timeout;
    id_value_d    = id_value;
    ts_value_d    = ts_value;
    capture       = 1'b0;

    case (state_q)
      IDLE: begin
        // auto_q is armed by reset, so exactly one automatic check per reset
        if (start || auto_q) begin
          state_d       = RD_ID;
          auto_d        = 1'b0;
          stall_d       = '0;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          busy_d        = 1'b1;
          pass_d        = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      RD_ID, RD_TS: begin
        if (avm_waitrequest) begin
          if (stall_q == STALL_LAST) begin
            state_d    = FIN;
            avm_read_d = 1'b0;
            timeout_d  = 1'b1;
            pass_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end else if (READ_LATENCY == 0) begin
          capture = 1'b1;
        end else begin
          avm_read_d = 1'b0;
          lat_d      = '0;
          state_d    = in_ts ? LAT_TS : LAT_ID;
        end
      end
      LAT_ID, LAT_TS: begin
        if (lat_q == LAT_LAST) capture = 1'b1;
        else                   lat_d   = lat_q + 3'd1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (!in_ts) begin
        id_value_d    = avm_readdata;
        id_ok_d       = id_match;
        state_d       = RD_TS;
        stall_d       = '0;
        avm_read_d    = 1'b1;
        avm_address_d = 1'b1;
      end else begin
        ts_value_d = avm_readdata;
        ts_ok_d    = ts_match;
        // timeout is necessarily clear when the timestamp is captured
        pass_d     = id_ok && ts_match;
        state_d    = FIN;
        avm_read_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: three differently parameterised instances, each
// with its own Avalon slave model, stimulus process and scoreboard monitor.
module tb_sysid_checker;

  localparam int NI = 3;
  localparam logic [31:0] P_EID  [NI] = '{32'd0, 32'h1234_5678, 32'hCAFE_0001};
  localparam logic [31:0] P_ETS  [NI] = '{32'd1444096058, 32'd1444096058, 32'h0BAD_F00D};
  localparam bit          P_CTS  [NI] = '{1'b1, 1'b0, 1'b1};
  localparam int unsigned P_LAT  [NI] = '{0, 2, 1};
  localparam int unsigned P_TO   [NI] = '{255, 4, 1};
  localparam bit          P_AUTO [NI] = '{1'b1, 1'b1, 1'b0};

  typedef struct {
    int unsigned n;
    int unsigned fin;
    int unsigned rc0;
    int unsigned rc1;
    logic        pass_e;
    logic        id_ok_e;
    logic        ts_ok_e;
    logic        to_e;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  logic        clock;
  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_fin = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc <= cyc + 1;
  end

  task automatic tick;
    @(negedge clock);
    #2;
  endtask

  task automatic chk32(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL i%0d %s: got 0x%08h, expected 0x%08h (cycle %0d)", inst, nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input int inst, input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL i%0d %s: got %b, expected %b (cycle %0d)", inst, nm, act, exp, cyc);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int          IDX  = gi;
    localparam logic [31:0] EID  = P_EID[gi];
    localparam logic [31:0] ETS  = P_ETS[gi];
    localparam bit          CTS  = P_CTS[gi];
    localparam int unsigned LAT  = P_LAT[gi];
    localparam int unsigned TO   = P_TO[gi];
    localparam bit          AUTO = P_AUTO[gi];
    localparam int unsigned LI   = (LAT == 0) ? 0 : LAT - 1;

    logic        reset, start, avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    sysid_checker #(
      .EXPECTED_ID        (EID),
      .EXPECTED_TIMESTAMP (ETS),
      .CHECK_TIMESTAMP    (CTS),
      .READ_LATENCY       (LAT),
      .TIMEOUT_CYCLES     (TO),
      .AUTO_START         (AUTO)
    ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .id_ok           (id_ok),
      .ts_ok           (ts_ok),
      .timeout         (timeout),
      .id_value        (id_value),
      .ts_value        (ts_value)
    );

    // Slave model: stalls each read for sl_s0/sl_s1 cycles; with latency the
    // word is only visible in the single cycle before the capturing edge.
    logic [31:0]       sl_id, sl_ts;
    int unsigned       sl_s0, sl_s1;
    int unsigned       sl_stall = 0;
    logic [7:0]        pv = '0;
    logic [7:0][31:0]  pd = '0;

    assign avm_waitrequest = avm_read && (sl_stall < (avm_address ? sl_s1 : sl_s0));
    assign avm_readdata    = (LAT == 0) ? (avm_address ? sl_ts : sl_id)
                                        : (pv[LI] ? pd[LI] : 32'hBADC_0FFE);

    initial forever begin
      @(posedge clock);
      if (avm_read && avm_waitrequest) sl_stall <= sl_stall + 1;
      else                             sl_stall <= 0;
      pv <= {pv[6:0], avm_read && !avm_waitrequest};
      pd <= {pd[6:0], (avm_address ? sl_ts : sl_id)};
    end

    // Scoreboard
    exp_t        q[$];
    logic [31:0] m_idv = '0;
    logic [31:0] m_tsv = '0;

    initial begin
      int unsigned rc0, rc1;
      logic        exp_busy;
      exp_t        e;
      rc0 = 0;
      rc1 = 0;
      forever begin
        @(negedge clock);
        if (reset) begin
          q.delete();
          rc0 = 0;
          rc1 = 0;
        end else begin
          if (avm_read) begin
            if (avm_address) rc1++;
            else             rc0++;
          end
          exp_busy = 1'b0;
          if (q.size() > 0) exp_busy = (cyc >= q[0].n) && (cyc < q[0].fin);
          chk1(IDX, "busy", busy, exp_busy);
          if (done) begin
            if (q.size() == 0) begin
              chk1(IDX, "spurious_done", done, 1'b0);
            end else begin
              e = q.pop_front();
              chk32(IDX, "done_cycle", cyc, e.fin);
              chk1(IDX, "pass", pass, e.pass_e);
              chk1(IDX, "id_ok", id_ok, e.id_ok_e);
              chk1(IDX, "ts_ok", ts_ok, e.ts_ok_e);
              chk1(IDX, "timeout", timeout, e.to_e);
              chk32(IDX, "id_value", id_value, e.idv);
              chk32(IDX, "ts_value", ts_value, e.tsv);
              chk32(IDX, "id_read_cycles", rc0, e.rc0);
              chk32(IDX, "ts_read_cycles", rc1, e.rc1);
            end
            rc0 = 0;
            rc1 = 0;
          end
        end
      end
    end

    // Reference: outcome and completion cycle of one check, from the words
    // the slave will return and its stall length on each address.
    task automatic push_exp(input int unsigned n, input logic [31:0] idw, input logic [31:0] tsw,
                            input int unsigned s0, input int unsigned s1, output int unsigned fin);
      exp_t        e;
      int unsigned ts_start;
      e.n = n; e.rc0 = 0; e.rc1 = 0;
      e.pass_e = 1'b0; e.id_ok_e = 1'b0; e.ts_ok_e = 1'b0; e.to_e = 1'b0;
      e.idv = m_idv; e.tsv = m_tsv;
      if (s0 >= TO) begin
        e.to_e = 1'b1; e.fin = n + TO; e.rc0 = TO;
      end else begin
        e.idv = idw; e.id_ok_e = (idw == EID); e.rc0 = s0 + 1;
        ts_start = n + 1 + s0 + LAT;
        if (s1 >= TO) begin
          e.to_e = 1'b1; e.fin = ts_start + TO; e.rc1 = TO;
        end else begin
          e.tsv = tsw; e.ts_ok_e = (tsw == ETS) || !CTS;
          e.pass_e = e.id_ok_e && e.ts_ok_e;
          e.fin = ts_start + 1 + s1 + LAT; e.rc1 = s1 + 1;
        end
      end
      m_idv = e.idv;
      m_tsv = e.tsv;
      q.push_back(e);
      fin = e.fin;
    endtask

    task automatic issue(input logic [31:0] idw, input logic [31:0] tsw,
                         input int unsigned s0, input int unsigned s1, output int unsigned fin);
      sl_id = idw; sl_ts = tsw; sl_s0 = s0; sl_s1 = s1;
      start = 1'b1;
      push_exp(cyc + 1, idw, tsw, s0, s1, fin);
      tick();
      start = 1'b0;
    endtask

    task automatic wait_idle;
      for (int k = 0; k < 3000 && q.size() != 0; k++) tick();
      chk32(IDX, "drain", q.size(), 0);
      tick();
    endtask

    task automatic run(input logic [31:0] idw, input logic [31:0] tsw,
                       input int unsigned s0, input int unsigned s1);
      int unsigned fin;
      issue(idw, tsw, s0, s1, fin);
      wait_idle();
    endtask

    task automatic check_zero;
      chk1(IDX, "rst_avm_read", avm_read, 1'b0);
      chk1(IDX, "rst_avm_address", avm_address, 1'b0);
      chk1(IDX, "rst_busy", busy, 1'b0);
      chk1(IDX, "rst_done", done, 1'b0);
      chk1(IDX, "rst_pass", pass, 1'b0);
      chk1(IDX, "rst_id_ok", id_ok, 1'b0);
      chk1(IDX, "rst_ts_ok", ts_ok, 1'b0);
      chk1(IDX, "rst_timeout", timeout, 1'b0);
      chk32(IDX, "rst_id_value", id_value, 32'd0);
      chk32(IDX, "rst_ts_value", ts_value, 32'd0);
    endtask

    task automatic do_reset;
      int unsigned fin;
      reset = 1'b1;
      start = 1'b0;
      #1;
      check_zero();
      tick();
      tick();
      m_idv = '0; m_tsv = '0;
      sl_id = EID; sl_ts = ETS; sl_s0 = 0; sl_s1 = 0;
      reset = 1'b0;
      if (AUTO) push_exp(cyc + 1, EID, ETS, 0, 0, fin);
    endtask

    function automatic int unsigned pick_stall();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6) return 0;
      if (r < 9) return $urandom_range(1, 3);
      return TO + $urandom_range(0, 2);
    endfunction

    initial begin
      int unsigned fin;
      logic [31:0] idw, tsw;
      start = 1'b0;
      sl_id = EID; sl_ts = ETS; sl_s0 = 0; sl_s1 = 0;
      do_reset();
      wait_idle();

      run(EID + 32'd1, ETS, 0, 0);
      run(EID, ETS ^ 32'h0000_0100, 0, 0);
      run(EID, ETS, 0, 3);
      run(EID, ETS, TO + 20, 0);
      run(EID, ETS, TO - 1, 0);
      run(EID, ETS, 0, TO);
      run(EID, ETS, 2, TO - 1);
      run(EID, ETS, 0, 0);

      // start while busy and start during the FIN cycle must both be dropped
      issue(EID, ETS, 0, 0, fin);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 2000 && cyc < fin; k++) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle();
      run(EID, ETS, 0, 0);

      for (int i = 0; i < 30; i++) begin
        idw = ($urandom_range(0, 3) == 0) ? $urandom : EID;
        tsw = ($urandom_range(0, 3) == 0) ? $urandom : ETS;
        run(idw, tsw, pick_stall(), pick_stall());
      end

      // reset during the last cycle of the timestamp read
      issue(EID, ETS, 0, 0, fin);
      for (int k = 0; k < 2000 && cyc + 1 < fin; k++) tick();
      do_reset();
      wait_idle();
      run(EID, ETS, 1, 0);

      n_fin++;
    end
  end

  initial begin
    for (int k = 0; k < 60000 && n_fin < NI; k++) @(negedge clock);
    if (n_fin < NI) begin
      n_cmp++;
      n_bad++;
      $display("FAIL global_timeout: %0d of %0d instances finished, expected %0d", n_fin, NI, NI);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
